// File: rtl/rs232_tx_arb.sv
// -----------------------------------------------------------------------------
// rs232_tx_arb
//   Round-robin arbiter that lets up to eight byte-stream requesters share one
//   buffered RS232 transmitter. A requester wins the channel for a whole
//   message (terminated by `last`). It keeps the channel until that message
//   ends, so messages from different requesters never interleave.
//
//   Optional feature (macro RS232_TX_ARB_TIMEOUT_EN):
//     An owner that shows no byte for `timeout` consecutive cycles is forced
//     off the channel, and timeout_evt pulses for one cycle. Without the macro
//     an owner holds the channel indefinitely and timeout_evt is tied to 0.
//
// Parameters
//   num_req     : number of requesters, 2..8
//   timeout     : idle-owner release limit in clk cycles, >= 2
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   req         : per-requester byte valid
//   data        : per-requester byte, requester i on [8i+7:8i]
//   last        : per-requester end-of-message flag, qualified by req
//   ack         : per-requester byte accepted this cycle
//   txb_full    : full flag of the buffered transmitter
//   txb_wr      : write strobe to the buffered transmitter
//   txb_data    : byte to the buffered transmitter (8'h00 while idle)
//   busy        : a requester owns the channel
//   owner       : index of the current or most recent owner
//   timeout_evt : one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rs232_tx_arb #(
  parameter int num_req = 4,
  parameter int timeout = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [num_req-1:0]   req,
  input  logic [num_req*8-1:0] data,
  input  logic [num_req-1:0]   last,
  output logic [num_req-1:0]   ack,
  input  logic                 txb_full,
  output logic                 txb_wr,
  output logic [7:0]           txb_data,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_evt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0] N4 = 4'(num_req);

  state_t     state, state_next;
  logic [2:0] ptr, ptr_next;
  logic [2:0] owner_next;
  logic [2:0] grant_idx;
  logic       grant_found;
  logic [2:0] owner_inc;
  logic       release_now;

  // Inputs padded to the maximum width of 8 requesters, so the owner index
  // (always 3 bits) selects a bit or byte without any width juggling.
  logic [7:0]  req8;
  logic [7:0]  last8;
  logic [63:0] data64;
  logic        req_own;
  logic        last_own;
  logic [7:0]  data_own;

  always_comb begin
    req8                = '0;
    last8               = '0;
    data64              = '0;
    req8[num_req-1:0]   = req;
    last8[num_req-1:0]  = last;
    data64[num_req*8-1:0] = data;
  end

  assign req_own  = req8[owner];
  assign last_own = last8[owner];
  assign data_own = data64[{owner, 3'b000} +: 8];

  // Round-robin search: first requester at or above ptr, wrapping at num_req.
  always_comb begin
    logic [3:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < num_req; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= N4) idx = idx - N4;
      if (!grant_found && req8[idx[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[2:0];
      end
    end
  end

  // Pointer for the next search after the owner releases.
  always_comb begin
    logic [3:0] inc4;
    inc4      = {1'b0, owner} + 4'd1;
    owner_inc = (inc4 == N4) ? 3'd0 : inc4[2:0];
  end

`ifdef RS232_TX_ARB_TIMEOUT_EN
  localparam int            CW      = $clog2(timeout);
  localparam logic [CW-1:0] CNT_MAX = CW'(timeout - 1);

  logic [CW-1:0] idle_cnt;
  logic          tmo_hit;

  // Expires on the timeout-th consecutive cycle without a byte from the
  // owner. A stalled owner (req high, txb_full high) is not idle.
  assign tmo_hit = (state == OWN) && !req_own && (idle_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= tmo_hit && !release_now;
      if (state != OWN || txb_wr || tmo_hit) begin
        idle_cnt <= '0;
      end else if (!req_own) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit     = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  // A normal end of message. It wins over an expiry in the same cycle.
  assign release_now = txb_wr && last_own;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    ack        = '0;
    txb_wr     = 1'b0;
    txb_data   = 8'h00;

    unique case (state)
      IDLE: begin
        if (grant_found) begin
          state_next = OWN;
          owner_next = grant_idx;
        end
      end
      OWN: begin
        txb_data = data_own;
        txb_wr   = req_own && !txb_full;
        for (int k = 0; k < num_req; k++) begin
          ack[k] = txb_wr && (owner == 3'(k));
        end
        if (release_now || tmo_hit) begin
          state_next = IDLE;
          ptr_next   = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the reset is asynchronous. Outputs decoded from state therefore
  // drop to their idle values as soon as rst_n falls, without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values.
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
    end
  end

  assign busy = (state == OWN);

endmodule

// File: tb/tb_rs232_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_rs232_tx_arb
//   Directed bench for rs232_tx_arb (num_req=4, timeout=8). A requester model
//   feeds per-requester byte queues into req/data/last and pops a byte after
//   each ack. Every transmitter write is checked against an expected
//   (owner, byte) queue by a negedge monitor. Cycle-exact checks of busy,
//   owner, ack and timeout_evt are made from the main thread.
// -----------------------------------------------------------------------------
module tb_rs232_tx_arb;

  localparam int NUM = 4;
  localparam int TMO = 8;

  typedef struct {
    logic [2:0] owner;
    logic [7:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NUM-1:0]   req  = '0;
  logic [NUM*8-1:0] data = '0;
  logic [NUM-1:0]   last = '0;
  logic [NUM-1:0]   ack;
  logic             txb_full;
  logic             txb_wr;
  logic [7:0]       txb_data;
  logic             busy;
  logic [2:0]       owner;
  logic             timeout_evt;

  int errors = 0;
  int checks = 0;

  logic [8:0]     rq [NUM][$];   // per-requester {last, byte}
  exp_t           sb [$];        // expected writes, in order
  logic [NUM-1:0] ack_q = '0;

  rs232_tx_arb #(.num_req(NUM), .timeout(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data        (data),
    .last        (last),
    .ack         (ack),
    .txb_full    (txb_full),
    .txb_wr      (txb_wr),
    .txb_data    (txb_data),
    .busy        (busy),
    .owner       (owner),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester model: pop the head after an ack, then present the new head.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM; i++) begin
      if (ack_q[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req[i]        = 1'b1;
        data[8*i +: 8] = rq[i][0][7:0];
        last[i]       = rq[i][0][8];
      end else begin
        req[i]        = 1'b0;
        data[8*i +: 8] = 8'h00;
        last[i]       = 1'b0;
      end
    end
  end

  // Monitor: every write must match the next expected (owner, byte).
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] ea;
    ack_q = ack;
    if (rst_n) begin
      if (txb_full) check("wr_while_full", {31'd0, txb_wr}, 32'd0);
      if (txb_wr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got owner %0d byte %0h expected no write", owner, txb_data);
        end else begin
          e  = sb.pop_front();
          ea = 4'b0001 << e.owner;
          check("wr_owner", {29'd0, owner}, {29'd0, e.owner});
          check("wr_data",  {24'd0, txb_data}, {24'd0, e.data});
          check("wr_ack",   {28'd0, ack}, {28'd0, ea});
        end
      end else begin
        check("ack_without_wr", {28'd0, ack}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_msg(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
    sb.push_back('{owner: 3'(r), data: d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM; i++) rq[i].delete();
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = (sb.size() == 0) && !busy;
      for (int i = 0; i < NUM; i++) if (rq[i].size() != 0) done = 1'b0;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    txb_full = 1'b0;

    // Reset values.
    #1;
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_owner", {29'd0, owner}, 32'd0);
    check("rst_wr",    {31'd0, txb_wr}, 32'd0);
    check("rst_ack",   {28'd0, ack}, 32'd0);
    check("rst_data",  {24'd0, txb_data}, 32'd0);
    check("rst_tmo",   {31'd0, timeout_evt}, 32'd0);
    do_reset();

    // Single one-byte message from requester 2.
    push_msg(2, 8'h41, 1'b1);
    tick();
    check("single_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("single_busy",  {31'd0, busy}, 32'd1);
    check("single_owner", {29'd0, owner}, 32'd2);
    check("single_ack",   {28'd0, ack}, 32'h4);
    check("single_wr",    {31'd0, txb_wr}, 32'd1);
    check("single_data",  {24'd0, txb_data}, 32'h41);
    tick();
    check("single_release", {31'd0, busy}, 32'd0);
    check("single_keep_owner", {29'd0, owner}, 32'd2);
    check("idle_data", {24'd0, txb_data}, 32'd0);
    wait_idle("single_drain", 20);

    // All four requesting: grants 0,1,2,3 then 0 again.
    do_reset();
    push_msg(0, 8'hA0, 1'b1);
    push_msg(1, 8'hA1, 1'b1);
    push_msg(2, 8'hA2, 1'b1);
    push_msg(3, 8'hA3, 1'b1);
    push_msg(0, 8'hB0, 1'b1);
    rq[0].delete();
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hB0});
    wait_idle("rr_drain", 40);

    // Owner 1 sends 3 bytes; byte 2 stalled by txb_full for 5 cycles.
    do_reset();
    push_msg(1, 8'h11, 1'b0);
    push_msg(1, 8'h12, 1'b0);
    push_msg(1, 8'h13, 1'b1);
    push_msg(3, 8'h31, 1'b1);
    tick();
    tick();
    check("stall_first_wr", {31'd0, txb_wr}, 32'd1);
    check("stall_owner0",   {29'd0, owner}, 32'd1);
    tick();
    txb_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_wr",    {31'd0, txb_wr}, 32'd0);
      check("stall_ack",   {28'd0, ack}, 32'd0);
      check("stall_busy",  {31'd0, busy}, 32'd1);
      check("stall_owner", {29'd0, owner}, 32'd1);
      tick();
    end
    txb_full = 1'b0;
    #1;
    check("stall_resume_wr",   {31'd0, txb_wr}, 32'd1);
    check("stall_resume_data", {24'd0, txb_data}, 32'h12);
    wait_idle("stall_drain", 30);

    // Owner 0 mid-message holds off requester 3.
    do_reset();
    push_msg(0, 8'h01, 1'b0);
    push_msg(0, 8'h02, 1'b0);
    push_msg(0, 8'h03, 1'b1);
    push_msg(3, 8'h3F, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_ack",   {28'd0, ack}, 32'h1);
      check("hold_owner", {29'd0, owner}, 32'd0);
    end
    tick();
    check("hold_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    check("hold_next_owner", {29'd0, owner}, 32'd3);
    check("hold_next_ack",   {28'd0, ack}, 32'h8);
    wait_idle("hold_drain", 20);

    // Owner 2 drops req after one byte.
    do_reset();
    push_msg(2, 8'h55, 1'b0);
    tick();
    tick();
    check("drop_first_wr", {31'd0, txb_wr}, 32'd1);
`ifdef RS232_TX_ARB_TIMEOUT_EN
    for (int c = 0; c < TMO; c++) begin
      tick();
      check("tmo_hold_busy", {31'd0, busy}, 32'd1);
      check("tmo_hold_evt",  {31'd0, timeout_evt}, 32'd0);
    end
    tick();
    check("tmo_evt",  {31'd0, timeout_evt}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    tick();
    check("tmo_evt_pulse", {31'd0, timeout_evt}, 32'd0);
    push_msg(3, 8'hC3, 1'b1);
    push_msg(0, 8'hC0, 1'b1);
    push_msg(1, 8'hC1, 1'b1);
    wait_idle("tmo_next_drain", 40);
`else
    for (int c = 0; c < 3 * TMO; c++) begin
      tick();
      check("no_tmo_busy",  {31'd0, busy}, 32'd1);
      check("no_tmo_owner", {29'd0, owner}, 32'd2);
      check("no_tmo_evt",   {31'd0, timeout_evt}, 32'd0);
    end
    push_msg(2, 8'h56, 1'b1);
    wait_idle("no_tmo_drain", 20);
`endif

    // Reset mid-message abandons it and restarts the search at 0.
    do_reset();
    push_msg(1, 8'h21, 1'b1);
    wait_idle("prep_drain", 20);
    push_msg(1, 8'h22, 1'b0);
    push_msg(1, 8'h23, 1'b0);
    push_msg(1, 8'h24, 1'b1);
    tick();
    tick();
    check("mid_pre_wr", {31'd0, txb_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr",    {31'd0, txb_wr}, 32'd0);
    check("mid_rst_ack",   {28'd0, ack}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_owner", {29'd0, owner}, 32'd0);
    check("mid_rst_data",  {24'd0, txb_data}, 32'd0);
    do_reset();
    push_msg(1, 8'h11, 1'b1);
    push_msg(3, 8'h33, 1'b1);
    wait_idle("restart_drain", 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
